// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: valid/ready request channel plus read-data return.
// The LSU drives the request side (master); the memory drives ready and the read return (slave).
interface load_store_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    dmem_req;
  logic                    dmem_we;
  logic [ADDRESS_BITS-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic [3:0]              dmem_be;
  logic                    dmem_ready;
  logic                    dmem_rvalid;
  logic [DATA_WIDTH-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one load or store per instruction over a valid/ready data port,
// with byte-lane steering on stores and sign/zero extension on loads. Stalls the core until done.
module load_store_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  access_error,
  load_store_unit_if.master     dmem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                  state_q;
  logic                    req_q;
  logic                    we_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              be_q;
  logic [2:0]              funct3_q;
  logic [1:0]              offset_q;
  logic [DATA_WIDTH-1:0]   load_data_q;
  logic                    load_valid_q;

  logic legal;
  logic aligned;
  logic start;
  logic unused_addr_hi;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b00:   return 4'b0001 << offset;
      2'b01:   return offset[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_lanes(input logic [1:0] size,
                                                        input logic [DATA_WIDTH-1:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] f3,
                                                         input logic [1:0] offset,
                                                         input logic [DATA_WIDTH-1:0] rdata);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    byte_s = rdata[{offset, 3'b000} +: 8];
    half_s = rdata[{offset[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return DATA_WIDTH'(byte_s);
      3'b001:  return DATA_WIDTH'(half_s);
      3'b100:  return DATA_WIDTH'($unsigned(byte_s));
      3'b101:  return DATA_WIDTH'($unsigned(half_s));
      default: return rdata;
    endcase
  endfunction

  assign legal = mem_read ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                          : (funct3 inside {3'b000, 3'b001, 3'b010});

  assign aligned = !((funct3[1:0] == 2'b01 && address[0]) ||
                     (funct3[1:0] == 2'b10 && address[1:0] != 2'b00));

  assign start = (state_q == IDLE) && req_valid && (mem_read ^ mem_write) && legal && aligned;

  // Gated by reset so both combinational outputs read 0 while reset is held.
  assign access_error = reset && (state_q == IDLE) && req_valid && !start;
  assign stall        = reset && (start || state_q == REQ || state_q == WAIT);

  // Memory sees a word-aligned address; only the low ADDRESS_BITS reach the port.
  assign unused_addr_hi = ^address[DATA_WIDTH-1:ADDRESS_BITS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      funct3_q     <= '0;
      offset_q     <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= REQ;
            req_q    <= 1'b1;
            we_q     <= mem_write;
            addr_q   <= {address[ADDRESS_BITS-1:2], 2'b00};
            wdata_q  <= store_lanes(funct3[1:0], store_data);
            be_q     <= lane_enables(funct3[1:0], address[1:0]);
            funct3_q <= funct3;
            offset_q <= address[1:0];
          end
        end
        REQ: begin
          if (dmem.dmem_ready) begin
            req_q   <= 1'b0;
            state_q <= we_q ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (dmem.dmem_rvalid) begin
            load_data_q  <= load_extract(funct3_q, offset_q, dmem.dmem_rdata);
            load_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;
  assign load_data       = load_data_q;
  assign load_valid      = load_valid_q;

endmodule
